// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer driving datapath control; 4 cycles ALU, 5+ load, 4+ store.
// Backpressure: stalls in FETCH/MEM until imem_ready/dmem_ready, halting with bus_error after TIMEOUT_CYCLES.
module core_sequencer #(
    parameter int addr_data_width = 32,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk1,
    input  logic                       reset1,
    input  logic                       run,
    input  logic                       halt_req,
    input  logic [addr_data_width-1:0] instruction,
    input  logic                       imem_ready,
    input  logic                       dmem_ready,
    output logic                       pc_en,
    output logic                       ir_load,
    output logic                       mdr_load,
    output logic [3:0]                 alu_op,
    output logic                       sel_bw_imm_rs2,
    output logic                       regfile_write_enable,
    output logic                       dmem_read_en,
    output logic                       dmem_write_en,
    output logic                       wr_back_sel,
    output logic [2:0]                 state,
    output logic                       illegal,
    output logic                       bus_error,
    output logic [addr_data_width-1:0] instr_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t                     st;
    logic [addr_data_width-1:0] ir_q;
    logic [TW-1:0]              tmo_q;
    logic                       wb_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       is_r, is_i, is_ld, is_st, is_valid;
    logic       tmo_last;
    logic       retire;
    logic       ir_unused;

    // All decode works from the latched copy, never the live memory bus.
    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign f7b5     = ir_q[30];
    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_valid = is_r | is_i | is_ld | is_st;
    assign ir_unused = ^{ir_q[addr_data_width-1:31], ir_q[29:15], ir_q[11:7]};

    always_comb begin
        alu_op = 4'b0000;
        if (is_r) begin
            alu_op = {f7b5, funct3};
        end else if (is_i) begin
            alu_op = (funct3 == 3'b101) ? {f7b5, funct3} : {1'b0, funct3};
        end
    end

    assign sel_bw_imm_rs2 = is_r;
    assign wr_back_sel    = ~is_ld;

    // Handshake strobes qualify registered state with the ready in the same cycle.
    assign tmo_last             = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign ir_load              = (st == S_FETCH) & imem_ready;
    assign mdr_load             = dmem_read_en & dmem_ready;
    assign pc_en                = wb_q | (dmem_write_en & dmem_ready);
    assign regfile_write_enable = wb_q;
    assign retire               = pc_en;
    assign state                = st;

    always_ff @(posedge clk1 or negedge reset1) begin
        if (!reset1) begin
            st            <= S_IDLE;
            ir_q          <= '0;
            tmo_q         <= '0;
            wb_q          <= 1'b0;
            dmem_read_en  <= 1'b0;
            dmem_write_en <= 1'b0;
            illegal       <= 1'b0;
            bus_error     <= 1'b0;
            instr_count   <= '0;
        end else begin
            wb_q <= 1'b0;
            if (retire) begin
                instr_count <= instr_count + addr_data_width'(1);
            end
            case (st)
                S_IDLE: begin
                    if (run) begin
                        st    <= S_FETCH;
                        tmo_q <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q <= instruction;
                        st   <= S_DECODE;
                    end else if (tmo_last) begin
                        bus_error <= 1'b1;
                        st        <= S_HALT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_DECODE: begin
                    if (is_valid) begin
                        st <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (is_ld || is_st) begin
                        st            <= S_MEM;
                        tmo_q         <= '0;
                        dmem_read_en  <= is_ld;
                        dmem_write_en <= is_st;
                    end else begin
                        st   <= S_WB;
                        wb_q <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_read_en  <= 1'b0;
                        dmem_write_en <= 1'b0;
                        if (is_ld) begin
                            st   <= S_WB;
                            wb_q <= 1'b1;
                        end else begin
                            st    <= (halt_req || !run) ? S_IDLE : S_FETCH;
                            tmo_q <= '0;
                        end
                    end else if (tmo_last) begin
                        dmem_read_en  <= 1'b0;
                        dmem_write_en <= 1'b0;
                        bus_error     <= 1'b1;
                        st            <= S_HALT;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_WB: begin
                    st    <= (halt_req || !run) ? S_IDLE : S_FETCH;
                    tmo_q <= '0;
                end
                S_HALT: begin
                    st <= S_HALT;
                end
                default: begin
                    st <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expectations queued per instruction, checked at each pc_en retire.
module tb_core_sequencer;

    logic        clk1 = 1'b0;
    logic        reset1;
    logic        run;
    logic        halt_req;
    logic [31:0] instruction;
    logic        imem_ready;
    logic        dmem_ready;
    logic        pc_en;
    logic        ir_load;
    logic        mdr_load;
    logic [3:0]  alu_op;
    logic        sel_bw_imm_rs2;
    logic        regfile_write_enable;
    logic        dmem_read_en;
    logic        dmem_write_en;
    logic        wr_back_sel;
    logic [2:0]  state;
    logic        illegal;
    logic        bus_error;
    logic [31:0] instr_count;

    always #5 clk1 = ~clk1;

    core_sequencer #(.addr_data_width(32), .TIMEOUT_CYCLES(16)) dut (
        .clk1                 (clk1),
        .reset1               (reset1),
        .run                  (run),
        .halt_req             (halt_req),
        .instruction          (instruction),
        .imem_ready           (imem_ready),
        .dmem_ready           (dmem_ready),
        .pc_en                (pc_en),
        .ir_load              (ir_load),
        .mdr_load             (mdr_load),
        .alu_op               (alu_op),
        .sel_bw_imm_rs2       (sel_bw_imm_rs2),
        .regfile_write_enable (regfile_write_enable),
        .dmem_read_en         (dmem_read_en),
        .dmem_write_en        (dmem_write_en),
        .wr_back_sel          (wr_back_sel),
        .state                (state),
        .illegal              (illegal),
        .bus_error            (bus_error),
        .instr_count          (instr_count)
    );

    typedef struct packed {
        logic [3:0]  alu;
        logic        sel;
        logic        wbs;
        logic        rfw;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   exp_cnt     = 0;
    int   rfw_pulses  = 0;
    int   exp_rfw     = 0;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 40) begin
            step();
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, s});
    endtask

    // Retire monitor: every pc_en must match the oldest queued instruction.
    always @(negedge clk1) begin : mon
        exp_t e;
        if (reset1 === 1'b1) begin
            if (dmem_read_en || dmem_write_en)
                check("mem_en_excl", {31'd0, dmem_read_en & dmem_write_en}, 32'd0);
            if (regfile_write_enable) rfw_pulses++;
            if (pc_en) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ret_alu_op", {28'd0, alu_op}, {28'd0, e.alu});
                    check("ret_sel", {31'd0, sel_bw_imm_rs2}, {31'd0, e.sel});
                    check("ret_wbsel", {31'd0, wr_back_sel}, {31'd0, e.wbs});
                    check("ret_rfw", {31'd0, regfile_write_enable}, {31'd0, e.rfw});
                    check("ret_count", instr_count, e.cnt);
                end
            end
        end
    end

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] ealu, input logic esel,
                             input int kind, input int dly, input logic hreq);
        exp_t  e;
        int    en_cycles;
        string tag;
        wait_state(3'd1, "fetch_reach");
        e.alu = ealu;
        e.sel = esel;
        e.wbs = (kind != K_LOAD);
        e.rfw = (kind != K_STORE);
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        exp_cnt++;
        if (kind != K_STORE) exp_rfw++;
        instruction = ins;
        imem_ready  = 1'b1;
        #1;
        check("ir_load", {31'd0, ir_load}, 32'd1);
        step();
        imem_ready  = 1'b0;
        instruction = 32'hFFFF_FFFF;
        check("st_decode", {29'd0, state}, 32'd2);
        check("ir_load_pulse", {31'd0, ir_load}, 32'd0);
        step();
        check("st_exec", {29'd0, state}, 32'd3);
        check("exec_alu_op", {28'd0, alu_op}, {28'd0, ealu});
        check("exec_sel", {31'd0, sel_bw_imm_rs2}, {31'd0, esel});
        if (hreq) halt_req = 1'b1;
        step();
        if (kind == K_ALU) begin
            check("st_wb", {29'd0, state}, 32'd5);
            check("wb_rfw", {31'd0, regfile_write_enable}, 32'd1);
            check("wb_pc_en", {31'd0, pc_en}, 32'd1);
        end else begin
            en_cycles = 0;
            tag = (kind == K_LOAD) ? "mdr_load" : "store_pc_en";
            check("st_mem", {29'd0, state}, 32'd4);
            for (int k = 0; k <= dly; k++) begin
                dmem_ready = (k == dly);
                #1;
                if ((kind == K_LOAD) ? dmem_read_en : dmem_write_en) en_cycles++;
                if (k == dly)
                    check(tag, {31'd0, (kind == K_LOAD) ? mdr_load : pc_en}, 32'd1);
                else
                    check("early_strobe", {31'd0, mdr_load | pc_en}, 32'd0);
                step();
            end
            dmem_ready = 1'b0;
            check("mem_en_cycles", en_cycles, dly + 1);
            check("mem_en_drop", {31'd0, dmem_read_en | dmem_write_en}, 32'd0);
            if (kind == K_LOAD) begin
                check("ld_st_wb", {29'd0, state}, 32'd5);
                check("ld_wbsel", {31'd0, wr_back_sel}, 32'd0);
                check("ld_rfw", {31'd0, regfile_write_enable}, 32'd1);
            end
        end
        if (kind != K_STORE) step();
        check("post_retire_state", {29'd0, state}, hreq ? 32'd0 : 32'd1);
        halt_req = 1'b0;
    endtask

    task automatic pulse_reset();
        reset1 = 1'b0;
        #1;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_flags", {30'd0, illegal, bus_error}, 32'd0);
        check("rst_count", instr_count, 32'd0);
        sb_q.delete();
        exp_cnt = 0;
        step();
        reset1 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset1 = 1'b0; run = 1'b0; halt_req = 1'b0;
        instruction = 32'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
        step();
        step();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_strobes", {26'd0, pc_en, ir_load, mdr_load, regfile_write_enable,
                              dmem_read_en, dmem_write_en}, 32'd0);
        check("rst_alu_sel", {27'd0, alu_op, sel_bw_imm_rs2}, 32'd0);
        check("rst_wbsel", {31'd0, wr_back_sel}, 32'd1);
        check("rst_flags", {30'd0, illegal, bus_error}, 32'd0);
        check("rst_count", instr_count, 32'd0);

        reset1 = 1'b1;
        step();
        check("idle_hold", {29'd0, state}, 32'd0);
        run = 1'b1;
        step();
        check("idle_to_fetch", {29'd0, state}, 32'd1);

        run_instr(32'h004182B3, 4'b0000, 1'b1, K_ALU,   0,  1'b0); // add
        run_instr(32'h40418333, 4'b1000, 1'b1, K_ALU,   0,  1'b0); // sub
        run_instr(32'h4021D293, 4'b1101, 1'b0, K_ALU,   0,  1'b0); // srai
        run_instr(32'h40008093, 4'b0000, 1'b0, K_ALU,   0,  1'b0); // addi, bit30 ignored
        run_instr(32'h0002A303, 4'b0000, 1'b0, K_LOAD,  3,  1'b0); // lw, late ready
        run_instr(32'h0041A423, 4'b0000, 1'b0, K_STORE, 0,  1'b0); // sw, immediate ready
        run_instr(32'h0002A303, 4'b0000, 1'b0, K_LOAD,  15, 1'b0); // ready on last allowed cycle
        run_instr(32'h004182B3, 4'b0000, 1'b1, K_ALU,   0,  1'b1); // halt_req raised in EXEC
        check("count_after_seq", instr_count, 32'd8);
        check("sb_drained", sb_q.size(), 32'd0);

        // Illegal opcode parks in HALT regardless of run.
        wait_state(3'd1, "ill_fetch_reach");
        instruction = 32'hFFFF_FFFF;
        imem_ready  = 1'b1;
        step();
        imem_ready  = 1'b0;
        check("ill_decode", {29'd0, state}, 32'd2);
        step();
        check("ill_halt", {29'd0, state}, 32'd6);
        check("ill_flag", {31'd0, illegal}, 32'd1);
        run = 1'b0;
        step();
        run = 1'b1;
        step();
        step();
        check("ill_stays_halt", {29'd0, state}, 32'd6);
        check("ill_no_retire", instr_count, 32'd8);
        pulse_reset();

        // Data-memory timeout on a load.
        wait_state(3'd1, "to_fetch_reach");
        instruction = 32'h0002A303;
        imem_ready  = 1'b1;
        step();
        imem_ready  = 1'b0;
        step();
        step();
        check("to_mem", {29'd0, state}, 32'd4);
        for (int k = 0; k < 16; k++) begin
            check("to_wait_rd_en", {29'd0, state[2:1], dmem_read_en}, {29'd0, 2'b10, 1'b1});
            step();
        end
        check("to_halt", {29'd0, state}, 32'd6);
        check("to_bus_error", {31'd0, bus_error}, 32'd1);
        check("to_en_drop", {31'd0, dmem_read_en}, 32'd0);
        check("to_no_retire", instr_count, 32'd0);
        pulse_reset();

        // Instruction-memory timeout.
        wait_state(3'd1, "ifto_fetch_reach");
        for (int k = 0; k < 16; k++) step();
        check("ifto_halt", {29'd0, state}, 32'd6);
        check("ifto_flags", {30'd0, illegal, bus_error}, 32'd1);

        check("rfw_pulse_total", rfw_pulses, exp_rfw);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the R/I/S-type RISC-V datapath. Sequences fetch, decode, execute, memory and write-back, and drives the datapath's control inputs: PC enable, IR load, ALU op, operand mux, register-file write, data-memory enables and write-back mux. Handshakes with instruction and data memories that have variable latency, and replaces the datapath's free-running PC and one-cycle decode.

Parameters:
addr_data_width, 32, instruction and counter width
TIMEOUT_CYCLES, 16, maximum wait cycles for imem_ready or dmem_ready before a bus error

Ports:
clk1  input  1  clock, rising edge
reset1  input  1  asynchronous, active-low reset
run  input  1  level; 1 lets the sequencer leave IDLE
halt_req  input  1  level; sampled at instruction retire
instruction  input  addr_data_width  instruction-memory read data
imem_ready  input  1  instruction data valid this cycle
dmem_ready  input  1  data-memory access completes this cycle
pc_en  output  1  one-cycle pulse; PC advances by 1
ir_load  output  1  one-cycle pulse; capture instruction
mdr_load  output  1  one-cycle pulse; capture load data
alu_op  output  4  {funct7[5], funct3}, using the datapath ALU encoding
sel_bw_imm_rs2  output  1  1 selects rs2, 0 selects immediate
regfile_write_enable  output  1  register-file write strobe
dmem_read_en  output  1  data-memory read enable
dmem_write_en  output  1  data-memory write enable
wr_back_sel  output  1  1 selects ALU result, 0 selects memory data
state  output  3  current state, for debug
illegal  output  1  sticky; unsupported opcode seen
bus_error  output  1  sticky; memory timeout
instr_count  output  addr_data_width  count of retired instructions

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (reset1=0, asynchronous):
  - State goes to IDLE.
  - All strobes and enables are 0; alu_op=0; sel_bw_imm_rs2=0; wr_back_sel=1.
  - illegal=0, bus_error=0, instr_count=0, internal instruction register=0, timeout counter=0.
  - Reset asserted mid-access abandons the access immediately. No PC pulse and no register-file write occurs.
- IDLE: if run=1, go to FETCH next edge; otherwise stay.
- FETCH:
  - Wait for imem_ready.
  - In the cycle imem_ready=1: ir_load=1, latch instruction internally on that edge, go to DECODE.
  - All later decode uses the latched copy only.
- DECODE (1 cycle): classify opcode[6:0].
  - 0110011 is R-type; 0010011 is I-ALU; 0000011 is load; 0100011 is store.
  - Any other opcode goes to HALT and sets illegal.
  - Valid opcodes go to EXEC.
- alu_op, held from DECODE through retire:
  - R-type: {funct7[5], funct3}.
  - I-ALU: {funct7[5], funct3} when funct3=101; {0, funct3} otherwise.
  - Load/store: 0000 (add).
- sel_bw_imm_rs2: 1 for R-type only.
- EXEC (1 cycle): R and I go to WB; load and store go to MEM.
- MEM:
  - Hold dmem_read_en (load) or dmem_write_en (store) continuously until and including the dmem_ready cycle.
  - Load: mdr_load=1 in the ready cycle, then go to WB.
  - Store: pc_en=1 in the ready cycle (retire).
- WB (1 cycle): regfile_write_enable=1 and pc_en=1.
  - wr_back_sel=0 for load, 1 otherwise.
- Retire cycle (WB, or store-MEM ready cycle):
  - instr_count increments, wrapping modulo 2^addr_data_width.
  - Next state is IDLE if halt_req=1 or run=0; FETCH otherwise.
  - halt_req never aborts an instruction in flight.
- Timeout:
  - The counter clears on entry to FETCH or MEM and increments each waiting cycle.
  - If TIMEOUT_CYCLES cycles elapse without ready, set bus_error and go to HALT. No strobes are issued and the enables drop.
  - A ready arriving on exactly cycle TIMEOUT_CYCLES is accepted (no error).
- HALT: all strobes 0; exit only by reset. illegal and bus_error stay set until reset.
- Strobes (pc_en, ir_load, mdr_load, regfile_write_enable) are exactly one cycle per occurrence. Each instruction produces exactly one pc_en pulse.
- The two memory enables are never both 1.

Test Plan:
- Reset, run=1, imem_ready=1, instruction=0x004182B3 (add) → states 1,2,3,5. alu_op=0000, sel_bw_imm_rs2=1, one regfile_write_enable and one pc_en pulse in WB, instr_count=1.
- Instruction 0x40418333 (sub), then 0x4021D293 (srai) → alu_op=1000 with sel=1; then alu_op=1101 with sel=0.
- 0x0002A303 (lw), dmem_ready asserted 3 cycles after MEM entry → dmem_read_en high for 4 cycles, mdr_load in the 4th, WB has wr_back_sel=0 and a write strobe.
- 0x0041A423 (sw), dmem_ready immediate → dmem_write_en for 1 cycle, pc_en in the same cycle, regfile_write_enable never asserted, next state FETCH.
- 0xFFFFFFFF → DECODE then HALT, illegal=1; run toggling has no effect until reset1 pulses low.
- lw with dmem_ready held 0 → bus_error=1 and HALT after 16 MEM cycles, no pc_en. Separately, halt_req=1 during EXEC → instruction completes, then IDLE.
